// File: rtl/virtio_notify_dispatch_pkg.sv
// Shared constants and FSM encoding for the virtio notify dispatcher.
package virtio_pkg;
  localparam logic [15:0] VIRTIO_MSI_NO_VECTOR     = 16'hFFFF;
  localparam int          DEV_STATUS_DRIVER_OK_BIT = 2;
  localparam int          PAGE_SHIFT_DEFAULT       = 12;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;
endpackage

// File: rtl/virtio_notify_dispatch_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping at NUM_Q.
module virtio_rr_arbiter #(
  parameter int NUM_Q = 3,
  parameter int IDX_W = 2
) (
  input  logic [NUM_Q-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);
  // Scan from the farthest offset down so the nearest offset wins.
  always_comb begin
    int idx;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int k = NUM_Q - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NUM_Q;
      if (req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/virtio_notify_dispatch.sv
// Virtio doorbell dispatcher: coalesces Queue Notify writes, issues one
// ring-processing request at a time in round-robin order, and turns fetch
// completions into MSI-X requests. Optional counter of coalesced notifies
// is built when VIRTIO_NOTIFY_STATS_EN is defined.
module virtio_notify_dispatch
  import virtio_pkg::*;
#(
  parameter int NUM_Q      = 3,
  parameter int QID_W      = 16,
  parameter int ADDR_W     = 64,
  parameter int PAGE_SHIFT = PAGE_SHIFT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                notify_vld,
  input  logic [QID_W-1:0]    notify_qid,
  input  logic                drv_ok,
  input  logic [NUM_Q*32-1:0] q_pfn,
  input  logic [NUM_Q*16-1:0] q_vec,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [QID_W-1:0]    req_qid,
  output logic [ADDR_W-1:0]   req_ring_addr,
  input  logic                done_valid,
  output logic                done_ready,
  input  logic [QID_W-1:0]    done_qid,
  output logic                msix_valid,
  input  logic                msix_ready,
  output logic [15:0]         msix_vec,
`ifdef VIRTIO_NOTIFY_STATS_EN
  output logic [31:0]         stat_coalesce,
`endif
  output logic                err_qid
);
  localparam int IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

  state_e              state_q, state_d;
  logic [NUM_Q-1:0]    pend_q, pend_d, busy_q, busy_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                req_valid_q, req_valid_d;
  logic [QID_W-1:0]    req_qid_q, req_qid_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                msix_valid_q, msix_valid_d;
  logic [15:0]         msix_vec_q, msix_vec_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    gnt_idx, n_idx, d_idx, cur_idx;
  logic                gnt_vld;
  logic                notify_ok, notify_bad, done_acc;
  logic [15:0]         d_vec;

  assign done_ready = !msix_valid_q;
  assign done_acc   = done_valid && !msix_valid_q;
  assign notify_ok  = notify_vld && drv_ok && (notify_qid < QID_W'(NUM_Q));
  assign notify_bad = notify_vld && drv_ok && (notify_qid >= QID_W'(NUM_Q));
  assign n_idx      = notify_qid[IDX_W-1:0];
  assign d_idx      = done_qid[IDX_W-1:0];
  assign cur_idx    = req_qid_q[IDX_W-1:0];
  assign d_vec      = q_vec[int'(d_idx)*16 +: 16];

  virtio_rr_arbiter #(.NUM_Q(NUM_Q), .IDX_W(IDX_W)) u_arb (
    .req_i     (pend_q & ~busy_q),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      busy_q       <= '0;
      rr_ptr_q     <= '0;
      req_valid_q  <= 1'b0;
      req_qid_q    <= '0;
      req_addr_q   <= '0;
      msix_valid_q <= 1'b0;
      msix_vec_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      rr_ptr_q     <= rr_ptr_d;
      req_valid_q  <= req_valid_d;
      req_qid_q    <= req_qid_d;
      req_addr_q   <= req_addr_d;
      msix_valid_q <= msix_valid_d;
      msix_vec_q   <= msix_vec_d;
      err_q        <= err_d;
    end
  end

  // Next state: completion, issue FSM, then notify (a notify beats the issue clear).
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    busy_d       = busy_q;
    rr_ptr_d     = rr_ptr_q;
    req_valid_d  = req_valid_q;
    req_qid_d    = req_qid_q;
    req_addr_d   = req_addr_q;
    msix_valid_d = msix_valid_q;
    msix_vec_d   = msix_vec_q;
    err_d        = 1'b0;

    if (msix_valid_q && msix_ready) msix_valid_d = 1'b0;

    if (done_acc) begin
      if (done_qid < QID_W'(NUM_Q)) begin
        busy_d[d_idx] = 1'b0;
        if (d_vec != VIRTIO_MSI_NO_VECTOR) begin
          msix_valid_d = 1'b1;
          msix_vec_d   = d_vec;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (drv_ok && gnt_vld) begin
          state_d         = ST_ISSUE;
          req_valid_d     = 1'b1;
          req_qid_d       = QID_W'(gnt_idx);
          req_addr_d      = ADDR_W'(q_pfn[int'(gnt_idx)*32 +: 32]) << PAGE_SHIFT;
          pend_d[gnt_idx] = 1'b0;
          busy_d[gnt_idx] = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          state_d     = ST_IDLE;
          req_valid_d = 1'b0;
          rr_ptr_d    = (int'(cur_idx) == NUM_Q - 1) ? '0 : cur_idx + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (notify_ok)  pend_d[n_idx] = 1'b1;
    if (notify_bad) err_d = 1'b1;
    if (!drv_ok)    pend_d = '0;
  end

`ifdef VIRTIO_NOTIFY_STATS_EN
  logic [31:0] stat_q;

  // Saturating count of notifies landing on a queue already pending or busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else if (notify_ok && (pend_q[n_idx] || busy_q[n_idx]) && (stat_q != 32'hFFFF_FFFF))
      stat_q <= stat_q + 32'd1;
  end

  assign stat_coalesce = stat_q;
`endif

  assign req_valid     = req_valid_q;
  assign req_qid       = req_qid_q;
  assign req_ring_addr = req_addr_q;
  assign msix_valid    = msix_valid_q;
  assign msix_vec      = msix_vec_q;
  assign err_qid       = err_q;
endmodule

// File: tb/tb_virtio_notify_dispatch.sv
// Bench for virtio_notify_dispatch: directed scenarios plus a randomized run
// compared against a rule-level model of the dispatcher.
module tb_virtio_notify_dispatch;
  localparam int NQ = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        notify_vld = 1'b0;
  logic [15:0] notify_qid = '0;
  logic        drv_ok = 1'b0;
  logic [NQ*32-1:0] q_pfn = '0;
  logic [NQ*16-1:0] q_vec = '0;
  logic        req_valid, req_ready = 1'b0;
  logic [15:0] req_qid;
  logic [63:0] req_ring_addr;
  logic        done_valid = 1'b0, done_ready;
  logic [15:0] done_qid = '0;
  logic        msix_valid, msix_ready = 1'b0;
  logic [15:0] msix_vec;
  logic        err_qid;
`ifdef VIRTIO_NOTIFY_STATS_EN
  logic [31:0] stat_coalesce;
`endif

  int checks = 0;
  int errors = 0;

  // Model state
  bit          m_pend[NQ];
  bit          m_busy[NQ];
  int          m_rr, m_qid;
  bit          m_req, m_msix, m_err;
  logic [63:0] m_addr;
  logic [15:0] m_vec;
  longint      m_stat;

  virtio_notify_dispatch #(.NUM_Q(NQ), .QID_W(16), .ADDR_W(64), .PAGE_SHIFT(12)) dut (
    .clk(clk), .rst_n(rst_n), .notify_vld(notify_vld), .notify_qid(notify_qid),
    .drv_ok(drv_ok), .q_pfn(q_pfn), .q_vec(q_vec), .req_valid(req_valid),
    .req_ready(req_ready), .req_qid(req_qid), .req_ring_addr(req_ring_addr),
    .done_valid(done_valid), .done_ready(done_ready), .done_qid(done_qid),
    .msix_valid(msix_valid), .msix_ready(msix_ready), .msix_vec(msix_vec),
`ifdef VIRTIO_NOTIFY_STATS_EN
    .stat_coalesce(stat_coalesce),
`endif
    .err_qid(err_qid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) begin m_pend[i] = 0; m_busy[i] = 0; end
    m_rr = 0; m_qid = 0; m_req = 0; m_msix = 0; m_err = 0;
    m_addr = '0; m_vec = '0; m_stat = 0;
  endtask

  // One clock: apply the dispatcher rules to the model, then settle.
  task automatic tick();
    bit np[NQ]; bit nb[NQ];
    bit n_req, n_msix, n_err, found;
    int n_rr, n_qid, idx, dq, nq;
    logic [63:0] n_addr; logic [15:0] n_vec;
    @(posedge clk);
    if (!rst_n) begin model_reset(); #1; return; end
    np = m_pend; nb = m_busy;
    n_req = m_req; n_msix = m_msix; n_err = 0; n_rr = m_rr; n_qid = m_qid;
    n_addr = m_addr; n_vec = m_vec;
    if (m_msix && msix_ready) n_msix = 0;
    if (done_valid && !m_msix) begin
      dq = int'(done_qid);
      if (dq < NQ) begin
        nb[dq] = 0;
        if (q_vec[16*dq +: 16] != 16'hFFFF) begin n_msix = 1; n_vec = q_vec[16*dq +: 16]; end
      end else n_err = 1;
    end
    if (m_req) begin
      if (req_ready) begin n_req = 0; n_rr = (m_qid + 1) % NQ; end
    end else if (drv_ok) begin
      found = 0;
      for (int k = 0; k < NQ; k++) begin
        idx = (m_rr + k) % NQ;
        if (!found && m_pend[idx] && !m_busy[idx]) begin
          found = 1; n_req = 1; n_qid = idx;
          n_addr = {32'h0, q_pfn[32*idx +: 32]} << 12;
          np[idx] = 0; nb[idx] = 1;
        end
      end
    end
    if (notify_vld && drv_ok) begin
      nq = int'(notify_qid);
      if (nq < NQ) begin
        if ((m_pend[nq] || m_busy[nq]) && m_stat < 64'hFFFF_FFFF) m_stat++;
        np[nq] = 1;
      end else n_err = 1;
    end
    if (!drv_ok) for (int i = 0; i < NQ; i++) np[i] = 0;
    m_pend = np; m_busy = nb; m_req = n_req; m_msix = n_msix; m_err = n_err;
    m_rr = n_rr; m_qid = n_qid; m_addr = n_addr; m_vec = n_vec;
    #1;
  endtask

  task automatic pulse_notify(input int q);
    notify_vld = 1'b1; notify_qid = 16'(q); tick(); notify_vld = 1'b0;
  endtask

  task automatic pulse_done(input int q);
    done_valid = 1'b1; done_qid = 16'(q); tick(); done_valid = 1'b0;
  endtask

  task automatic do_reset();
    notify_vld = 0; done_valid = 0; req_ready = 0; msix_ready = 0;
    rst_n = 1'b0; #1; model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
    checks++; if (req_qid !== 16'h0) begin errors++; $display("FAIL reset_req_qid got %h want 0", req_qid); end
    checks++; if (req_ring_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", req_ring_addr); end
    checks++; if (msix_valid !== 1'b0) begin errors++; $display("FAIL reset_msix_valid got %b want 0", msix_valid); end
    checks++; if (msix_vec !== 16'h0) begin errors++; $display("FAIL reset_msix_vec got %h want 0", msix_vec); end
    checks++; if (err_qid !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_qid); end
    checks++; if (done_ready !== 1'b1) begin errors++; $display("FAIL reset_done_ready got %b want 1", done_ready); end
  endtask

  task automatic test_basic();
    int n = 0;
    do_reset();
    drv_ok = 1; q_pfn[63:32] = 32'h0001_2345; q_vec[31:16] = 16'h0002; req_ready = 1;
    pulse_notify(1);
    while (req_valid !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_timeout got %b want 1", req_valid); end
    checks++; if (req_qid !== 16'd1) begin errors++; $display("FAIL basic_req_qid got %0d want 1", req_qid); end
    checks++; if (req_ring_addr !== 64'h0000_0000_1234_5000) begin errors++; $display("FAIL basic_addr got %h want 0000000012345000", req_ring_addr); end
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL basic_req_drop got %b want 0", req_valid); end
    pulse_done(1);
    checks++; if (msix_valid !== 1'b1 || msix_vec !== 16'h0002) begin errors++; $display("FAIL basic_msix got v=%b vec=%h want v=1 vec=0002", msix_valid, msix_vec); end
    msix_ready = 1; tick(); msix_ready = 0;
    checks++; if (msix_valid !== 1'b0) begin errors++; $display("FAIL basic_msix_clear got %b want 0", msix_valid); end
  endtask

  task automatic test_coalesce();
    int rises = 0; bit prev = 0;
`ifdef VIRTIO_NOTIFY_STATS_EN
    logic [31:0] s0;
`endif
    do_reset();
    drv_ok = 1; req_ready = 0;
`ifdef VIRTIO_NOTIFY_STATS_EN
    s0 = stat_coalesce;
`endif
    for (int i = 0; i < 3; i++) begin
      if (req_valid && !prev) rises++;
      prev = req_valid;
      pulse_notify(0);
    end
    for (int i = 0; i < 8; i++) begin
      if (req_valid && !prev) rises++;
      prev = req_valid;
      tick();
    end
    checks++; if (rises !== 1) begin errors++; $display("FAIL coalesce_req_count got %0d want 1", rises); end
    checks++; if (req_qid !== 16'd0) begin errors++; $display("FAIL coalesce_qid got %0d want 0", req_qid); end
`ifdef VIRTIO_NOTIFY_STATS_EN
    checks++; if (stat_coalesce - s0 !== 32'd2) begin errors++; $display("FAIL coalesce_stat got %0d want 2", stat_coalesce - s0); end
`endif
  endtask

  task automatic test_round_robin();
    int got[$]; int exp1[3] = '{0, 1, 2}; int exp2[2] = '{0, 2};
    do_reset();
    drv_ok = 1; req_ready = 0; q_vec = '1;
    pulse_notify(0); pulse_notify(1); pulse_notify(2);
    req_ready = 1;
    for (int i = 0; i < 20; i++) begin if (req_valid) got.push_back(int'(req_qid)); tick(); end
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL rr_count1 got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp1[i]) begin errors++; $display("FAIL rr_order1[%0d] got %0d want %0d", i, got[i], exp1[i]); end
    end
    req_ready = 0;
    pulse_done(0); pulse_done(1); pulse_done(2);
    got.delete();
    pulse_notify(0); pulse_notify(2);
    req_ready = 1;
    for (int i = 0; i < 20; i++) begin if (req_valid) got.push_back(int'(req_qid)); tick(); end
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL rr_count2 got %0d want 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp2[i]) begin errors++; $display("FAIL rr_order2[%0d] got %0d want %0d", i, got[i], exp2[i]); end
    end
  endtask

  task automatic test_busy_block();
    int n = 0; int seen = 0;
    do_reset();
    drv_ok = 1; req_ready = 1; q_vec = '1;
    pulse_notify(2);
    while (req_valid !== 1'b1 && n < 10) begin tick(); n++; end
    tick();
    pulse_notify(2);
    for (int i = 0; i < 8; i++) begin if (req_valid) seen++; tick(); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL busy_blocked got %0d request cycles want 0", seen); end
    req_ready = 0;
    pulse_done(2);
    n = 0;
    while (req_valid !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (req_valid !== 1'b1 || req_qid !== 16'd2) begin errors++; $display("FAIL busy_reissue got v=%b qid=%0d want v=1 qid=2", req_valid, req_qid); end
  endtask

  task automatic test_novec_backpressure();
    do_reset();
    drv_ok = 1; q_vec = '1; q_vec[31:16] = 16'h0005; msix_ready = 0;
    pulse_done(0);
    checks++; if (msix_valid !== 1'b0) begin errors++; $display("FAIL novec_msix got %b want 0", msix_valid); end
    pulse_done(1);
    checks++; if (msix_valid !== 1'b1 || msix_vec !== 16'h0005) begin errors++; $display("FAIL bp_msix got v=%b vec=%h want v=1 vec=0005", msix_valid, msix_vec); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (done_ready !== 1'b0) begin errors++; $display("FAIL bp_done_ready[%0d] got %b want 0", i, done_ready); end
      tick();
    end
    msix_ready = 1; tick(); msix_ready = 0;
    checks++; if (msix_valid !== 1'b0 || done_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", msix_valid, done_ready); end
  endtask

  task automatic test_errors_reset();
    int n = 0; int seen = 0;
    do_reset();
    drv_ok = 1; req_ready = 0;
    pulse_notify(5);
    checks++; if (err_qid !== 1'b1) begin errors++; $display("FAIL err_notify_pulse got %b want 1", err_qid); end
    for (int i = 0; i < 5; i++) begin if (req_valid) seen++; tick(); end
    checks++; if (seen !== 0 || err_qid !== 1'b0) begin errors++; $display("FAIL err_notify_after got req=%0d err=%b want 0 0", seen, err_qid); end
    pulse_done(7);
    checks++; if (err_qid !== 1'b1 || done_ready !== 1'b1) begin errors++; $display("FAIL err_done got err=%b rdy=%b want 1 1", err_qid, done_ready); end
    drv_ok = 0; pulse_notify(5);
    checks++; if (err_qid !== 1'b0) begin errors++; $display("FAIL err_drvok_off got %b want 0", err_qid); end
    drv_ok = 1;
    pulse_notify(1);
    while (req_valid !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL reset_mid_setup got %b want 1", req_valid); end
    rst_n = 1'b0; #1; model_reset();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_async got %b want 0", req_valid); end
    tick(); rst_n = 1'b1; tick();
    seen = 0;
    for (int i = 0; i < 5; i++) begin if (req_valid) seen++; tick(); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_pend_cleared got %0d want 0", seen); end
    pulse_notify(1); tick();
    checks++; if (req_valid !== 1'b1 || req_qid !== 16'd1) begin errors++; $display("FAIL reset_busy_cleared got v=%b qid=%0d want 1 1", req_valid, req_qid); end
  endtask

  task automatic test_random();
    do_reset();
    drv_ok = 1;
    for (int i = 0; i < NQ; i++) begin
      q_pfn[32*i +: 32] = $urandom;
      q_vec[16*i +: 16] = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
    end
    for (int c = 0; c < 3000; c++) begin
      notify_vld = ($urandom_range(0, 2) == 0);
      notify_qid = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 59) == 0) drv_ok = ~drv_ok;
      req_ready  = $urandom_range(0, 1);
      done_valid = ($urandom_range(0, 3) == 0);
      done_qid   = 16'($urandom_range(0, 3));
      msix_ready = $urandom_range(0, 1);
      tick();
      checks++;
      if (req_valid !== m_req || req_qid !== 16'(m_qid) || req_ring_addr !== m_addr ||
          msix_valid !== m_msix || msix_vec !== m_vec || err_qid !== m_err || done_ready !== !m_msix) begin
        errors++;
        $display("FAIL random_cyc%0d got rv=%b q=%0d a=%h mv=%b vec=%h e=%b dr=%b want rv=%b q=%0d a=%h mv=%b vec=%h e=%b dr=%b",
                 c, req_valid, req_qid, req_ring_addr, msix_valid, msix_vec, err_qid, done_ready,
                 m_req, m_qid, m_addr, m_msix, m_vec, m_err, !m_msix);
      end
`ifdef VIRTIO_NOTIFY_STATS_EN
      checks++; if (stat_coalesce !== 32'(m_stat)) begin errors++; $display("FAIL random_stat got %0d want %0d", stat_coalesce, m_stat); end
`endif
    end
    notify_vld = 0; done_valid = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_coalesce();
    test_round_robin();
    test_busy_block();
    test_novec_backpressure();
    test_errors_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
